// File: rtl/bus_share_arbiter.sv
// bus_share_arbiter
//
// Round-robin owner selection for a four-way shared tri-state bus. Each
// requester i drives the bus through an output register whose output
// disable is cs[i] (1 = high-Z). A grant holds the bus for at most MaxHold
// Tick-qualified beats. Every grant is followed by one TURN beat with all
// drivers disabled, so two registers never fight over the bus.
//
// Parameters
//   MaxHold : maximum Tick-qualified beats per grant, legal range 1..16
//
// Ports
//   Clock   : system clock, rising edge
//   Reset   : asynchronous, active-high; returns everything to IDLE
//   Tick    : clock enable; state, pointer and counter move only when 1
//   req     : level request per requester
//   abort   : ends the current grant on the next Tick edge (DRIVE only)
//   cs      : per-register output disable, 1 = high-Z
//   gnt     : one-hot grant, always the complement of cs
//   owner   : index of the current or just-released grantee, 0 in IDLE
//   busy    : 1 while in DRIVE or TURN
//
// All outputs come straight from flops, so nothing combinational from req,
// abort or Tick reaches cs or gnt.

`timescale 1ns/1ps

module bus_share_arbiter #(
    parameter int MaxHold = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    input  logic [3:0] req,
    input  logic       abort,
    output logic [3:0] cs,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Beat count at which a grant must end; the counter starts at 0 on entry.
    localparam logic [3:0] LastBeat = 4'(MaxHold - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [1:0] owner_nxt;
    logic [3:0] cs_nxt;
    logic [3:0] gnt_nxt;
    logic       busy_nxt;
    logic [1:0] winner;
    logic [3:0] winner_oh;
    logic       drive_done;

    // First set request bit scanning p, p+1, ... modulo 4. Only consulted
    // when at least one bit is set, so the fall-through value is irrelevant.
    function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                               input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        logic       found;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    assign winner     = pick_winner(req, ptr);
    assign winner_oh  = one_hot(winner);
    assign drive_done = !req[owner] || (cnt == LastBeat) || abort;

    // Next-state and next-output logic. Without Tick everything holds.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        cs_nxt    = cs;
        gnt_nxt   = gnt;
        busy_nxt  = busy;

        if (Tick) begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state_nxt = DRIVE;
                        owner_nxt = winner;
                        gnt_nxt   = winner_oh;
                        cs_nxt    = ~winner_oh;
                        cnt_nxt   = 4'd0;
                        busy_nxt  = 1'b1;
                    end
                end

                DRIVE: begin
                    if (drive_done) begin
                        // Release the bus; the pointer moves past the
                        // released owner so it only wins again when alone.
                        state_nxt = TURN;
                        cs_nxt    = 4'b1111;
                        gnt_nxt   = 4'b0000;
                        ptr_nxt   = owner + 2'd1;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end

                TURN: begin
                    // ptr was updated on entry to TURN, so winner already
                    // reflects the rotated priority.
                    if (|req) begin
                        state_nxt = DRIVE;
                        owner_nxt = winner;
                        gnt_nxt   = winner_oh;
                        cs_nxt    = ~winner_oh;
                        cnt_nxt   = 4'd0;
                        busy_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        owner_nxt = 2'd0;
                        busy_nxt  = 1'b0;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    ptr_nxt   = 2'd0;
                    cnt_nxt   = 4'd0;
                    owner_nxt = 2'd0;
                    cs_nxt    = 4'b1111;
                    gnt_nxt   = 4'b0000;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            owner <= 2'd0;
            cs    <= 4'b1111;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
            cs    <= cs_nxt;
            gnt   <= gnt_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule
